// File: rtl/cost_rom_arbiter.sv
// cost_rom_arbiter
// Shares the single-ported 8x8 job-cost table between two assignment-search
// engines. Round-robin grant, locked bursts with a stall timeout, zero-bubble
// handover, and a fixed two-cycle read return routed back to the requester
// that issued the transfer.
module cost_rom_arbiter #(
    parameter int BURST_LEN    = 8,
    parameter int IDLE_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req0,
    input  logic       i_lock0,
    input  logic [2:0] i_w0,
    input  logic [2:0] i_j0,
    input  logic       i_req1,
    input  logic       i_lock1,
    input  logic [2:0] i_w1,
    input  logic [2:0] i_j1,
    output logic       o_gnt0,
    output logic       o_gnt1,
    output logic       o_rvalid0,
    output logic       o_rvalid1,
    output logic [6:0] o_rdata0,
    output logic [6:0] o_rdata1,
    output logic [2:0] o_w,
    output logic [2:0] o_j,
    output logic       o_rom_en,
    input  logic [6:0] i_cost
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);
    localparam logic [2:0] STALL_LAST = 3'(IDLE_TIMEOUT - 1);

    state_t     r_state;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_rr;
    logic [3:0] r_burst_cnt;
    logic [2:0] r_stall_cnt;
    logic [2:0] r_w_last;
    logic [2:0] r_j_last;
    logic       r_tag_valid;
    logic       r_tag_id;
    logic       r_rvalid0;
    logic       r_rvalid1;
    logic [6:0] r_rdata0;
    logic [6:0] r_rdata1;

    logic       w_own0;
    logic       w_own1;
    logic       w_owner_id;
    logic       w_req_own;
    logic       w_lock_own;
    logic       w_req_oth;
    logic       w_xfer;
    logic       w_release;
    logic [2:0] w_addr_w;
    logic [2:0] w_addr_j;
    state_t     w_next_state;

    // Owner view: the current owner's request/lock, the contender's request.
    assign w_own0     = (r_state == ST_OWN0);
    assign w_own1     = (r_state == ST_OWN1);
    assign w_owner_id = w_own1;
    assign w_req_own  = w_own1 ? i_req1  : i_req0;
    assign w_lock_own = w_own1 ? i_lock1 : i_lock0;
    assign w_req_oth  = w_own1 ? i_req0  : i_req1;
    assign w_xfer     = (w_own0 & i_req0) | (w_own1 & i_req1);
    assign w_addr_w   = w_own1 ? i_w1 : i_w0;
    assign w_addr_j   = w_own1 ? i_j1 : i_j0;

    // End of tenure: unlocked transfer, full burst, unlocked drop, or stall timeout.
    assign w_release = (w_own0 | w_own1) &
                       ( w_req_own ? (!w_lock_own || (r_burst_cnt == BURST_LAST))
                                   : (!w_lock_own || (r_stall_cnt == STALL_LAST)) );

    // Next-state selection: winner from IDLE, handover or re-grant on release.
    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req0 && i_req1) begin
                    w_next_state = r_rr ? ST_OWN1 : ST_OWN0;
                end else if (i_req0) begin
                    w_next_state = ST_OWN0;
                end else if (i_req1) begin
                    w_next_state = ST_OWN1;
                end
            end
            default: begin
                if (w_release) begin
                    if (w_req_oth) begin
                        w_next_state = w_own1 ? ST_OWN0 : ST_OWN1;
                    end else if (!w_req_own) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // Arbitration FSM with registered grants, round-robin pointer and tenure counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rr        <= 1'b0;
            r_burst_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next_state;
            r_gnt0  <= (w_next_state == ST_OWN0);
            r_gnt1  <= (w_next_state == ST_OWN1);
            if (w_release) begin
                r_rr <= ~w_owner_id;
            end
            if ((r_state == ST_IDLE) || w_release) begin
                r_burst_cnt <= '0;
                r_stall_cnt <= '0;
            end else if (w_xfer) begin
                r_burst_cnt <= r_burst_cnt + 4'd1;
                r_stall_cnt <= '0;
            end else begin
                // Owner not requesting and not released means it is holding the lock.
                r_stall_cnt <= r_stall_cnt + 3'd1;
            end
        end
    end

    // Remember the last table address so W/J hold between transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_last <= '0;
            r_j_last <= '0;
        end else if (w_xfer) begin
            r_w_last <= w_addr_w;
            r_j_last <= w_addr_j;
        end
    end

    // Tag each transfer, then steer the table data to the requester that issued it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_valid <= 1'b0;
            r_tag_id    <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_tag_valid <= w_xfer;
            r_tag_id    <= w_owner_id;
            r_rvalid0   <= r_tag_valid & ~r_tag_id;
            r_rvalid1   <= r_tag_valid &  r_tag_id;
            if (r_tag_valid && !r_tag_id) begin
                r_rdata0 <= i_cost;
            end
            if (r_tag_valid && r_tag_id) begin
                r_rdata1 <= i_cost;
            end
        end
    end

    assign o_gnt0    = r_gnt0;
    assign o_gnt1    = r_gnt1;
    assign o_rom_en  = w_xfer;
    assign o_w       = w_xfer ? w_addr_w : r_w_last;
    assign o_j       = w_xfer ? w_addr_j : r_j_last;
    assign o_rvalid0 = r_rvalid0;
    assign o_rvalid1 = r_rvalid1;
    assign o_rdata0  = r_rdata0;
    assign o_rdata1  = r_rdata1;

endmodule

// File: tb/tb_cost_rom_arbiter.sv
// Testbench for cost_rom_arbiter: directed scenarios plus random traffic.
// A transaction-level model predicts grants and addresses each cycle and
// queues the expected read returns; a separate monitor pops them whenever the
// DUT pulses RVALID.
module tb_cost_rom_arbiter;

    localparam int BURST_LEN    = 8;
    localparam int IDLE_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, lock0, req1, lock1;
    logic [2:0] w0, j0, w1, j1;
    logic       gnt0, gnt1, rvalid0, rvalid1, rom_en;
    logic [6:0] rdata0, rdata1;
    logic [2:0] w, j;
    logic [6:0] cost = 7'd0;

    logic [6:0] cost_tab [8][8];

    typedef struct {
        int id;
        int data;
        int due;
    } ret_t;

    ret_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int m_owner, m_rr, m_burst, m_stall, m_last_w, m_last_j;
    int exp_rdata [2];
    int pulses [2];

    cost_rom_arbiter #(
        .BURST_LEN   (BURST_LEN),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req0   (req0),
        .i_lock0  (lock0),
        .i_w0     (w0),
        .i_j0     (j0),
        .i_req1   (req1),
        .i_lock1  (lock1),
        .i_w1     (w1),
        .i_j1     (j1),
        .o_gnt0   (gnt0),
        .o_gnt1   (gnt1),
        .o_rvalid0(rvalid0),
        .o_rvalid1(rvalid1),
        .o_rdata0 (rdata0),
        .o_rdata1 (rdata1),
        .o_w      (w),
        .o_j      (j),
        .o_rom_en (rom_en),
        .i_cost   (cost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cost table: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (rom_en) cost <= cost_tab[w][j];
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: evaluated mid-cycle with stable inputs.
    always @(negedge clk) begin
        bit rq [2];
        bit lk [2];
        int aw [2];
        int aj [2];
        bit xfer;
        bit done;
        int x;
        if (!rst_n) begin
            check("rst_gnt0", gnt0, 0);
            check("rst_gnt1", gnt1, 0);
            check("rst_rvalid0", rvalid0, 0);
            check("rst_rvalid1", rvalid1, 0);
            check("rst_rdata0", rdata0, 0);
            check("rst_rdata1", rdata1, 0);
            check("rst_w", w, 0);
            check("rst_j", j, 0);
            check("rst_rom_en", rom_en, 0);
            m_owner = -1; m_rr = 0; m_burst = 0; m_stall = 0;
            m_last_w = 0; m_last_j = 0;
            exp_q.delete();
        end else begin
            rq[0] = req0; rq[1] = req1; lk[0] = lock0; lk[1] = lock1;
            aw[0] = w0;   aw[1] = w1;   aj[0] = j0;    aj[1] = j1;
            done = 0;
            check("gnt0", gnt0, (m_owner == 0) ? 1 : 0);
            check("gnt1", gnt1, (m_owner == 1) ? 1 : 0);
            xfer = (m_owner >= 0) ? rq[m_owner] : 1'b0;
            if (xfer) begin
                m_last_w = aw[m_owner];
                m_last_j = aj[m_owner];
                exp_q.push_back('{m_owner, int'(cost_tab[m_last_w][m_last_j]), cyc + 2});
            end
            check("rom_en", rom_en, xfer ? 1 : 0);
            check("addr_w", w, m_last_w);
            check("addr_j", j, m_last_j);
            // Advance the model to the state after this edge.
            if (m_owner < 0) begin
                if (rq[0] || rq[1]) begin
                    m_owner = (rq[0] && rq[1]) ? m_rr : (rq[0] ? 0 : 1);
                    m_burst = 0;
                    m_stall = 0;
                end
            end else begin
                x = m_owner;
                if (xfer) begin
                    m_burst++;
                    m_stall = 0;
                    done = !lk[x] || (m_burst == BURST_LEN);
                end else if (lk[x]) begin
                    m_stall++;
                    done = (m_stall == IDLE_TIMEOUT);
                end else begin
                    done = 1;
                end
                if (done) begin
                    m_rr    = 1 - x;
                    m_burst = 0;
                    m_stall = 0;
                    m_owner = rq[1 - x] ? (1 - x) : (rq[x] ? x : -1);
                end
            end
        end
    end

    // Monitor: pops the expected return whenever the DUT presents read data.
    always @(negedge clk) begin
        ret_t it;
        if (!rst_n) begin
            exp_rdata[0] = 0;
            exp_rdata[1] = 0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                it = exp_q.pop_front();
                check("rvalid_missing_at", cyc, it.due);
            end
            if (rvalid0 || rvalid1) begin
                if (rvalid0) pulses[0]++;
                if (rvalid1) pulses[1]++;
                if (exp_q.size() == 0) begin
                    check("rvalid_unexpected", {rvalid1, rvalid0}, 0);
                end else begin
                    it = exp_q.pop_front();
                    check("rvalid_cycle", cyc, it.due);
                    check("rvalid_id", {rvalid1, rvalid0}, (it.id == 1) ? 2 : 1);
                    exp_rdata[it.id] = it.data;
                end
            end
            check("rdata0", rdata0, exp_rdata[0]);
            check("rdata1", rdata1, exp_rdata[1]);
        end
    end

    task automatic step(input bit r0, input bit l0, input int a0, input int b0,
                        input bit r1, input bit l1, input int a1, input int b1);
        req0 = r0; lock0 = l0; w0 = 3'(a0); j0 = 3'(b0);
        req1 = r1; lock1 = l1; w1 = 3'(a1); j1 = 3'(b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                cost_tab[a][b] = 7'($urandom_range(0, 127));
            end
        end
        cost_tab[3][5] = 7'd42;
        pulses[0] = 0;
        pulses[1] = 0;
        rst_n = 1'b0;
        req0 = 0; lock0 = 0; w0 = 0; j0 = 0;
        req1 = 0; lock1 = 0; w1 = 0; j1 = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0);

        // Single access to table[3][5].
        step(1, 0, 3, 5, 0, 0, 0, 0);
        step(1, 0, 3, 5, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);
        check("single_rdata0", rdata0, 42);
        check("single_rdata1", rdata1, 0);

        // Locked burst of 8 with requester 1 contending from the 2nd transfer.
        pulses[0] = 0;
        step(1, 1, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            step(1, 1, k, 7 - k, (k >= 1) ? 1'b1 : 1'b0, 0, 6, 6);
        end
        step(0, 0, 0, 0, 1, 0, 1, 2);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);
        check("burst_rvalid0_pulses", pulses[0], BURST_LEN);

        // Round-robin tie with both requesters unlocked.
        repeat (6) step(1, 0, $urandom_range(0, 7), $urandom_range(0, 7),
                        1, 0, $urandom_range(0, 7), $urandom_range(0, 7));
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);

        // Stall timeout: owner 1 holds the lock without requesting.
        step(0, 0, 0, 0, 1, 1, 2, 2);
        step(0, 0, 0, 0, 1, 1, 4, 4);
        repeat (IDLE_TIMEOUT) step(1, 0, 5, 6, 0, 1, 0, 0);
        step(1, 0, 5, 6, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);

        // Burst overflow: 10 locked transfers with no contender.
        pulses[1] = 0;
        step(0, 0, 0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0, 1, 1, k % 8, (k * 3) % 8);
        end
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);
        check("overflow_rvalid1_pulses", pulses[1], 10);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 7));
        end
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a locked burst with reads in flight.
        step(1, 1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 2, 2, 0, 0, 0, 0);
        step(1, 1, 3, 3, 0, 0, 0, 0);
        pulses[0] = 0;
        rst_n = 1'b0;
        req0 = 0; lock0 = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0);
        check("post_reset_rvalid0_pulses", pulses[0], 0);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
